// File: rtl/counter_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_cmd_pkg
//  Purpose  : Shared opcode and state encodings for the serial command
//             front-end of the loadable counter.
//  Revision : 1.0  initial release
// ============================================================================
package counter_cmd_pkg;

  // Width of the opcode field that starts every frame.
  localparam int OP_W = 2;

  // Opcode values, transmitted MSB first.
  localparam logic [OP_W-1:0] OP_NOP    = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD   = 2'b01;
  localparam logic [OP_W-1:0] OP_OE_ON  = 2'b10;
  localparam logic [OP_W-1:0] OP_OE_OFF = 2'b11;

  // Frame deserialiser states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_load_ctrl_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : idle_timer
//  Purpose  : Counts consecutive cycles in which a running transfer sees no
//             activity and flags expiry on the cycle the count would reach
//             TIMEOUT. A kick on that same cycle wins and prevents expiry.
//             TIMEOUT = 0 disables the timer entirely.
//  Revision : 1.0  initial release
// ============================================================================
module idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_kick,
  output logic o_expire
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      // Timer disabled: the inputs are intentionally unused.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, i_run, i_kick};
      assign o_expire = 1'b0;
    end else begin : g_enabled
      localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

      logic [c_CNT_W-1:0] r_cnt;
      logic               w_expire;

      // Expire on the idle cycle that would take the count to TIMEOUT.
      assign w_expire = i_run && !i_kick && (r_cnt == c_LAST);
      assign o_expire = w_expire;

      // Idle-cycle counter: held at zero outside a transfer, on activity and on expiry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (!i_run || i_kick || w_expire) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/counter_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_load_ctrl
//  Purpose  : Bit-serial command front-end for the loadable counter. Decodes
//             2-bit opcodes (plus a DATA_W payload for LOAD) and drives a
//             one-cycle load strobe with a parallel value and a sticky
//             output enable. Stalled frames are aborted by an idle timeout.
//  Revision : 1.0  initial release
// ============================================================================
module counter_load_ctrl
  import counter_cmd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ser_in,
  input  logic              i_ser_valid,
  output logic              o_load,
  output logic [DATA_W-1:0] o_load_in,
  output logic              o_en,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam int                 c_CNT_W    = $clog2(DATA_W);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);

  state_t              r_state;
  logic                r_op_msb;
  logic [DATA_W-2:0]   r_shift;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic                r_load;
  logic [DATA_W-1:0]   r_load_in;
  logic                r_en;
  logic                r_frame_err;

  logic                w_run;
  logic                w_expire;
  logic [DATA_W-1:0]   w_shift_next;
  logic [OP_W-1:0]     w_opcode;

  // The shift register only holds DATA_W-1 bits; the final bit completes the word.
  assign w_shift_next = {r_shift, i_ser_in};
  assign w_opcode     = {r_op_msb, i_ser_in};
  assign w_run        = (r_state != ST_IDLE);

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_run),
    .i_kick   (i_ser_valid),
    .o_expire (w_expire)
  );

  // Frame FSM: opcode capture, payload shift, registered load/en/frame_err outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op_msb    <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_load      <= 1'b0;
      r_load_in   <= '0;
      r_en        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_ser_valid) begin
            r_op_msb <= i_ser_in;
            r_state  <= ST_OP;
          end
        end
        ST_OP: begin
          if (i_ser_valid) begin
            case (w_opcode)
              OP_LOAD: begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_state   <= ST_DATA;
              end
              OP_OE_ON: begin
                r_en    <= 1'b1;
                r_state <= ST_IDLE;
              end
              OP_OE_OFF: begin
                r_en    <= 1'b0;
                r_state <= ST_IDLE;
              end
              default: begin
                r_state <= ST_IDLE;
              end
            endcase
          end else if (w_expire) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (i_ser_valid) begin
            if (r_bit_cnt == c_LAST_BIT) begin
              // Value and strobe are registered together so the counter never sees a stale word.
              r_load_in <= w_shift_next;
              r_load    <= 1'b1;
              r_shift   <= '0;
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_shift   <= w_shift_next[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end else if (w_expire) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_load      = r_load;
  assign o_load_in   = r_load_in;
  assign o_en        = r_en;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_counter_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_load_ctrl
//  Purpose  : Self-checking bench for counter_load_ctrl. Expected load values
//             are queued as LOAD frames are sent and consumed on each load
//             pulse; per-scenario tasks check en, busy and frame_err inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_ser_in = 1'b0;
  logic       i_ser_valid = 1'b0;
  logic       o_load;
  logic [7:0] o_load_in;
  logic       o_en;
  logic       o_busy;
  logic       o_frame_err;

  int         n_cmp = 0;
  int         n_err = 0;
  int         load_pulses = 0;
  int         ferr_pulses = 0;
  logic [7:0] exp_q[$];

  counter_load_ctrl #(
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ser_in    (i_ser_in),
    .i_ser_valid (i_ser_valid),
    .o_load      (o_load),
    .o_load_in   (o_load_in),
    .o_en        (o_en),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample 1ns after the edge, and retire load pulses against the scoreboard.
  task automatic tick();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    if (o_load === 1'b1) begin
      load_pulses++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL load_unexpected: load pulse with load_in=%h, required no load", o_load_in);
      end else begin
        exp = exp_q.pop_front();
        if (o_load_in !== exp) begin
          n_err++;
          $display("FAIL load_value: load_in=%h, required %h", o_load_in, exp);
        end
      end
    end
    if (o_frame_err === 1'b1) ferr_pulses++;
  endtask

  task automatic send_bit(input logic b);
    i_ser_valid = 1'b1;
    i_ser_in    = b;
    tick();
    i_ser_valid = 1'b0;
    i_ser_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Full LOAD frame with 'gap' idle cycles before every bit after the first.
  task automatic send_load(input logic [7:0] val, input int gap);
    send_bit(1'b0);
    idle(gap);
    send_bit(1'b1);
    for (int i = 7; i >= 0; i--) begin
      idle(gap);
      if (i == 0) exp_q.push_back(val);
      send_bit(val[i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({o_load, o_load_in, o_en, o_busy, o_frame_err} !== 12'h000) begin
        n_err++;
        $display("FAIL reset_outputs: load=%b load_in=%h en=%b busy=%b ferr=%b, required all 0",
                 o_load, o_load_in, o_en, o_busy, o_frame_err);
      end
      i_ser_in    = 1'($urandom_range(0, 1));
      i_ser_valid = 1'($urandom_range(0, 1));
      tick();
    end
    i_ser_valid = 1'b0;
    i_ser_in    = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int         p0;
    logic [7:0] v;
    v  = 8'hA5;
    p0 = load_pulses;
    send_bit(1'b0);
    n_cmp++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL load_busy_op: busy=%b, required 1", o_busy); end
    send_bit(1'b1);
    for (int i = 7; i >= 1; i--) begin
      n_cmp++;
      if (o_busy !== 1'b1 || o_load !== 1'b0) begin
        n_err++;
        $display("FAIL load_busy_data: busy=%b load=%b, required busy=1 load=0", o_busy, o_load);
      end
      send_bit(v[i]);
    end
    exp_q.push_back(v);
    send_bit(v[0]);
    n_cmp++;
    if (o_load !== 1'b1 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_strobe: load=%b busy=%b, required load=1 busy=0", o_load, o_busy);
    end
    tick();
    n_cmp++;
    if (o_load !== 1'b0 || o_load_in !== 8'hA5) begin
      n_err++;
      $display("FAIL load_hold: load=%b load_in=%h, required load=0 load_in=a5", o_load, o_load_in);
    end
    idle(3);
    n_cmp++;
    if (load_pulses - p0 != 1) begin
      n_err++;
      $display("FAIL load_count: pulses=%0d, required 1", load_pulses - p0);
    end
  endtask

  task automatic test_oe();
    int p0;
    p0 = load_pulses;
    send_bit(1'b1);
    n_cmp++;
    if (o_en !== 1'b0) begin n_err++; $display("FAIL oe_on_early: en=%b, required 0", o_en); end
    send_bit(1'b0);
    n_cmp++;
    if (o_en !== 1'b1 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL oe_on: en=%b busy=%b, required en=1 busy=0", o_en, o_busy);
    end
    send_bit(1'b0);
    send_bit(1'b0);
    n_cmp++;
    if (o_en !== 1'b1) begin n_err++; $display("FAIL oe_nop: en=%b, required 1", o_en); end
    send_bit(1'b1);
    n_cmp++;
    if (o_en !== 1'b1) begin n_err++; $display("FAIL oe_off_early: en=%b, required 1", o_en); end
    send_bit(1'b1);
    n_cmp++;
    if (o_en !== 1'b0) begin n_err++; $display("FAIL oe_off: en=%b, required 0", o_en); end
    idle(2);
    n_cmp++;
    if (load_pulses != p0 || o_load_in !== 8'hA5) begin
      n_err++;
      $display("FAIL oe_no_load: pulses=%0d load_in=%h, required 0 pulses load_in=a5",
               load_pulses - p0, o_load_in);
    end
  endtask

  task automatic test_back_to_back();
    int p0, f0;
    p0 = load_pulses;
    f0 = ferr_pulses;
    send_load(8'h3C, 3);
    n_cmp++;
    if (o_load !== 1'b1 || o_load_in !== 8'h3C) begin
      n_err++;
      $display("FAIL gapped_load: load=%b load_in=%h, required load=1 load_in=3c", o_load, o_load_in);
    end
    send_load(8'hC3, 0);
    idle(2);
    n_cmp++;
    if (o_load_in !== 8'hC3 || load_pulses - p0 != 2 || ferr_pulses != f0) begin
      n_err++;
      $display("FAIL back_to_back: load_in=%h pulses=%0d ferr=%0d, required c3 2 0",
               o_load_in, load_pulses - p0, ferr_pulses - f0);
    end
  endtask

  task automatic test_timeout_boundary();
    int f0;
    f0 = ferr_pulses;
    send_load(8'h96, 15);
    idle(2);
    n_cmp++;
    if (ferr_pulses != f0 || o_load_in !== 8'h96) begin
      n_err++;
      $display("FAIL timeout_boundary: ferr=%0d load_in=%h, required 0 96", ferr_pulses - f0, o_load_in);
    end
  endtask

  task automatic test_timeout();
    int p0, f0;
    p0 = load_pulses;
    f0 = ferr_pulses;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(15);
    n_cmp++;
    if (o_busy !== 1'b1 || o_frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: busy=%b ferr=%b, required busy=1 ferr=0", o_busy, o_frame_err);
    end
    tick();
    n_cmp++;
    if (o_frame_err !== 1'b1 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_abort: ferr=%b busy=%b, required ferr=1 busy=0", o_frame_err, o_busy);
    end
    tick();
    n_cmp++;
    if (o_frame_err !== 1'b0 || ferr_pulses - f0 != 1 || load_pulses != p0 || o_load_in !== 8'h96) begin
      n_err++;
      $display("FAIL timeout_after: ferr=%b pulses=%0d loads=%0d load_in=%h, required 0 1 0 96",
               o_frame_err, ferr_pulses - f0, load_pulses - p0, o_load_in);
    end
    send_load(8'h5A, 0);
    idle(1);
    n_cmp++;
    if (o_load_in !== 8'h5A || load_pulses - p0 != 1) begin
      n_err++;
      $display("FAIL timeout_reload: load_in=%h pulses=%0d, required 5a 1", o_load_in, load_pulses - p0);
    end
  endtask

  task automatic test_reset_midframe();
    int p0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 5; k++) send_bit(1'b1);
    n_cmp++;
    if (o_en !== 1'b1 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_setup: en=%b busy=%b, required 1 1", o_en, o_busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_load, o_load_in, o_en, o_busy, o_frame_err} !== 12'h000) begin
      n_err++;
      $display("FAIL midframe_reset: load=%b load_in=%h en=%b busy=%b ferr=%b, required all 0",
               o_load, o_load_in, o_en, o_busy, o_frame_err);
    end
    i_ser_valid = 1'b1;
    i_ser_in    = 1'b1;
    tick();
    tick();
    i_ser_valid = 1'b0;
    i_ser_in    = 1'b0;
    rst_n = 1'b1;
    p0 = load_pulses;
    send_load(8'hFF, 0);
    idle(2);
    n_cmp++;
    if (o_load_in !== 8'hFF || load_pulses - p0 != 1 || o_en !== 1'b0) begin
      n_err++;
      $display("FAIL midframe_reload: load_in=%h pulses=%0d en=%b, required ff 1 0",
               o_load_in, load_pulses - p0, o_en);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_oe();
    test_back_to_back();
    test_timeout_boundary();
    test_timeout();
    test_reset_midframe();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
